// File: rtl/cpu_regs_pkg.sv
// Shared CPU register-file definitions: data width, register indices and
// the fetch sequencer state encoding.
package cpu_regs_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  // Register-file indices used by the fetch path.
  localparam logic [SEL_W-1:0] REG_PC   = 4'd0;
  localparam logic [SEL_W-1:0] REG_SP   = 4'd8;
  localparam logic [SEL_W-1:0] REG_PCP  = 4'd9;
  localparam logic [SEL_W-1:0] REG_FLG  = 4'd10;
  localparam logic [SEL_W-1:0] REG_INST = 4'd11;

  typedef enum logic [2:0] {
    F_IDLE    = 3'd0,
    F_RD_PC   = 3'd1,
    F_MEM     = 3'd2,
    F_WR_INST = 3'd3,
    F_WR_PCP  = 3'd4,
    F_WR_PC   = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer. Reads PC from the register file, fetches the
// word at PC from memory, then writes INST, PCP (old PC) and PC+PC_INC back.
// It owns the register-file port only while busy.
//
// Memory handshake: mem_req is held high with a stable mem_addr for every
// MEM cycle; a cycle with mem_req=1 and mem_ack=1 completes the transfer and
// mem_rdata is captured on that edge. mem_ack is ignored when mem_req=0.
// If no ack arrives within ACK_TIMEOUT MEM cycles the fetch is abandoned
// without touching the register file.
module instr_fetch_seq
  import cpu_regs_pkg::*;
#(
  parameter logic [DATA_W-1:0] PC_INC      = 16'd1,
  parameter int                ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [SEL_W-1:0]  rf_sel,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_write,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output fetch_state_t      fsm_state
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;

  // The current MEM cycle is the last one allowed before abort.
  assign cnt_last  = (cnt == CNT_LAST);
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= F_IDLE;
    else       state <= state_nx;
  end

  // Datapath registers and the one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      inst_q <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      fault  <= 1'b0;
    end else begin
      done  <= (state == F_WR_PC);
      // An ack on the final wait cycle still completes the fetch.
      fault <= (state == F_MEM) && !mem_ack && cnt_last;
      unique case (state)
        F_RD_PC: begin
          pc_q <= rf_rdata;
          cnt  <= '0;
        end
        F_MEM: begin
          if (mem_ack) inst_q <= mem_rdata;
          else         cnt    <= cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      F_IDLE:    if (start) state_nx = F_RD_PC;
      F_RD_PC:   state_nx = F_MEM;
      F_MEM: begin
        if (mem_ack)       state_nx = F_WR_INST;
        else if (cnt_last) state_nx = F_IDLE;
      end
      F_WR_INST: state_nx = F_WR_PCP;
      F_WR_PCP:  state_nx = F_WR_PC;
      F_WR_PC:   state_nx = F_IDLE;
      default:   state_nx = F_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so they hold steady
  // across each cycle and cannot move while rf_write is high.
  always_comb begin
    busy     = (state != F_IDLE);
    rf_sel   = REG_PC;
    rf_wdata = '0;
    rf_write = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
    unique case (state)
      F_RD_PC: rf_sel = REG_PC;
      F_MEM: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      F_WR_INST: begin
        rf_sel   = REG_INST;
        rf_wdata = inst_q;
        rf_write = 1'b1;
      end
      F_WR_PCP: begin
        rf_sel   = REG_PCP;
        rf_wdata = pc_q;
        rf_write = 1'b1;
      end
      F_WR_PC: begin
        rf_sel   = REG_PC;
        rf_wdata = pc_q + PC_INC;
        rf_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: register-file and memory models around the DUT,
// a transaction-level reference model with a per-cycle compare, directed
// scenarios with literal expectations, then a randomized phase.
module tb_instr_fetch_seq;
  import cpu_regs_pkg::*;

  localparam int ACK_TIMEOUT = 15;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, fault, rf_write, mem_req;
  logic [3:0]   rf_sel;
  logic [15:0]  rf_wdata, rf_rdata, mem_addr;
  logic         mem_ack = 1'b0;
  logic [15:0]  mem_rdata = 16'h0;
  fetch_state_t fsm_state;

  always #5 clk = ~clk;

  instr_fetch_seq #(.PC_INC(16'd1), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .fault(fault), .rf_sel(rf_sel), .rf_wdata(rf_wdata), .rf_write(rf_write),
    .rf_rdata(rf_rdata), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  // ---------------- register file model ----------------
  logic [15:0] rf_m [16] = '{default: 16'h0};
  logic        set_req = 1'b0;
  logic [15:0] set_val = 16'h0;

  assign rf_rdata = rf_m[rf_sel];

  always @(posedge clk) begin
    if (rf_write)     rf_m[rf_sel] <= rf_wdata;
    else if (set_req) rf_m[REG_PC] <= set_val;
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- memory responder controls ----------------
  int          ack_delay  = 0;     // MEM cycles before ack; -1 = never
  logic        use_fixed  = 1'b1;
  logic [15:0] fixed_word = 16'h0;
  logic        rand_delay = 1'b0;
  logic        spur_en    = 1'b0;
  int          cur_delay  = 0;
  int          req_cyc    = 0;

  // ---------------- reference model state ----------------
  logic        s_reset = 1'b1, s_start = 1'b0, s_ack = 1'b0;
  logic [15:0] s_rdata = 16'h0;
  int          m_mode = 0;         // 0 idle, 1 reading PC, 2 waiting memory, 3 writing back
  int          m_wait = 0;
  logic [15:0] m_pc = 16'h0;
  logic        m_done_exp = 1'b0, m_fault_exp = 1'b0;
  logic [19:0] exp_q[$];           // {sel, data} writes still owed
  int          wr_cnt = 0, done_cnt = 0, fault_cnt = 0, req_cnt = 0;

  // Inputs as the DUT saw them on each rising edge.
  always @(posedge clk) begin
    s_reset <= reset;
    s_start <= start;
    s_ack   <= mem_ack;
    s_rdata <= mem_rdata;
  end

  // Advance the model over the last edge, compare, then drive memory.
  always @(negedge clk) begin
    m_done_exp  = 1'b0;
    m_fault_exp = 1'b0;
    if (s_reset) begin
      m_mode = 0;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (s_start) m_mode = 1;
        1: begin
          m_mode = 2;
          m_pc   = rf_m[REG_PC];
          m_wait = 0;
        end
        2: begin
          m_wait++;
          if (s_ack) begin
            exp_q.push_back({REG_INST, s_rdata});
            exp_q.push_back({REG_PCP, m_pc});
            exp_q.push_back({REG_PC, 16'(m_pc + 16'd1)});
            m_mode = 3;
          end else if (m_wait == ACK_TIMEOUT) begin
            m_mode      = 0;
            m_fault_exp = 1'b1;
          end
        end
        default: begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_mode     = 0;
            m_done_exp = 1'b1;
          end
        end
      endcase
    end

    chk("done_fault_excl", {31'd0, done & fault}, 32'd0);
    chk("done", {31'd0, done}, {31'd0, m_done_exp});
    chk("fault", {31'd0, fault}, {31'd0, m_fault_exp});
    chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_mode == 2});
    chk("rf_write", {31'd0, rf_write}, {31'd0, m_mode == 3});
    if (m_mode == 1) chk("rd_sel", {28'd0, rf_sel}, {28'd0, REG_PC});
    if (m_mode == 2) chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_pc});
    if (m_mode == 3 && exp_q.size() > 0) begin
      chk("wr_sel", {28'd0, rf_sel}, {28'd0, exp_q[0][19:16]});
      chk("wr_data", {16'd0, rf_wdata}, {16'd0, exp_q[0][15:0]});
    end

    if (rf_write) wr_cnt++;
    if (done)     done_cnt++;
    if (fault)    fault_cnt++;
    if (mem_req)  req_cnt++;

    if (mem_req) begin
      if (req_cyc == 0) begin
        if (rand_delay) begin
          case ($urandom_range(0, 9))
            0:       cur_delay = -1;
            1:       cur_delay = ACK_TIMEOUT - 1;
            default: cur_delay = int'($urandom_range(0, 4));
          endcase
        end else begin
          cur_delay = ack_delay;
        end
      end
      mem_ack   = (cur_delay >= 0) && (req_cyc == cur_delay);
      mem_rdata = use_fixed ? fixed_word : 16'($urandom);
      req_cyc++;
    end else begin
      req_cyc   = 0;
      mem_ack   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pc(input logic [15:0] v);
    set_val = v;
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
  endtask

  // Pulse start for one edge; lat = edges from the sampling edge until
  // done or fault is seen, -1 if neither shows up.
  task automatic do_fetch(input int delay, output int lat, output logic got_fault);
    ack_delay = delay;
    lat       = -1;
    got_fault = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done || fault) begin
        lat       = i;
        got_fault = fault;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int          lat;
  logic        gf;
  int          w0, d0, f0, r0;
  logic [15:0] pc0;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rf_sel", {28'd0, rf_sel}, 32'd0);
    chk("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Ack in the first MEM cycle.
    set_pc(16'h0040);
    fixed_word = 16'hA5C3;
    do_fetch(0, lat, gf);
    chk("t1_latency", lat, 32'd5);
    chk("t1_no_fault", {31'd0, gf}, 32'd0);
    chk("t1_inst", {16'd0, rf_m[REG_INST]}, 32'h0000A5C3);
    chk("t1_pcp", {16'd0, rf_m[REG_PCP]}, 32'h00000040);
    chk("t1_pc", {16'd0, rf_m[REG_PC]}, 32'h00000041);
    repeat (2) @(negedge clk);

    // Ack delayed by three cycles.
    set_pc(16'h0040);
    r0 = req_cnt;
    do_fetch(3, lat, gf);
    repeat (2) @(negedge clk);
    chk("t2_latency", lat, 32'd8);
    chk("t2_req_cycles", req_cnt - r0, 32'd4);
    chk("t2_inst", {16'd0, rf_m[REG_INST]}, 32'h0000A5C3);
    chk("t2_pcp", {16'd0, rf_m[REG_PCP]}, 32'h00000040);
    chk("t2_pc", {16'd0, rf_m[REG_PC]}, 32'h00000041);

    // No ack at all: abort with a single fault pulse and no writes.
    set_pc(16'h0100);
    w0 = wr_cnt;
    f0 = fault_cnt;
    d0 = done_cnt;
    do_fetch(-1, lat, gf);
    repeat (3) @(negedge clk);
    chk("t3_fault_seen", {31'd0, gf}, 32'd1);
    chk("t3_latency", lat, 32'd16);
    chk("t3_fault_pulses", fault_cnt - f0, 32'd1);
    chk("t3_no_done", done_cnt - d0, 32'd0);
    chk("t3_no_writes", wr_cnt - w0, 32'd0);
    chk("t3_pc_kept", {16'd0, rf_m[REG_PC]}, 32'h00000100);

    // Ack on the very last allowed wait cycle still completes.
    fixed_word = 16'h5A5A;
    set_pc(16'h0200);
    do_fetch(ACK_TIMEOUT - 1, lat, gf);
    chk("t7_latency", lat, 32'd19);
    chk("t7_no_fault", {31'd0, gf}, 32'd0);
    chk("t7_inst", {16'd0, rf_m[REG_INST]}, 32'h00005A5A);
    chk("t7_pc", {16'd0, rf_m[REG_PC]}, 32'h00000201);
    repeat (2) @(negedge clk);

    // PC wrap.
    set_pc(16'hFFFF);
    do_fetch(1, lat, gf);
    chk("t4_pc_wrap", {16'd0, rf_m[REG_PC]}, 32'h00000000);
    chk("t4_pcp", {16'd0, rf_m[REG_PCP]}, 32'h0000FFFF);
    repeat (2) @(negedge clk);

    // Reset while writing PCP: PC keeps its value, no done pulse.
    set_pc(16'h0300);
    d0 = done_cnt;
    f0 = fault_cnt;
    ack_delay = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rf_write && rf_sel == REG_PCP) break;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy_after_reset", {31'd0, busy}, 32'd0);
    chk("t5_no_write_after_reset", {31'd0, rf_write}, 32'd0);
    repeat (6) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 32'd0);
    chk("t5_no_fault", fault_cnt - f0, 32'd0);
    chk("t5_pc_kept", {16'd0, rf_m[REG_PC]}, 32'h00000300);

    // start held high: back-to-back fetches, one PC step per fetch.
    set_pc(16'h1000);
    d0 = done_cnt;
    ack_delay = 0;
    spur_en = 1'b1;
    start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_idle(40);
    pc0 = 16'h1000 + 16'(done_cnt - d0);
    chk("t6_fetch_count", done_cnt - d0, 32'd7);
    chk("t6_pc_advance", {16'd0, rf_m[REG_PC]}, {16'd0, pc0});

    // Randomized phase: random starts, ack delays, data and stray acks.
    use_fixed  = 1'b0;
    rand_delay = 1'b1;
    set_pc(16'($urandom));
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 3) == 0);
      if (i % 200 == 199 && $urandom_range(0, 1) == 1) reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    start = 1'b0;
    wait_idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
